// File: rtl/vote_pkg.sv
// Shared definitions for the vote frame parser: sync byte, parser states,
// the buffered vote record and the frame checksum.
package vote_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    ID_HI = 3'd1,
    ID_LO = 3'd2,
    CAND  = 3'd3,
    CHECK = 3'd4
  } parse_state_t;

  typedef struct packed {
    logic [15:0] voter_id;
    logic [7:0]  candidate;
  } vote_entry_t;

  function automatic logic [7:0] frame_checksum(input logic [7:0] id_hi,
                                                input logic [7:0] id_lo,
                                                input logic [7:0] cand);
    return id_hi ^ id_lo ^ cand;
  endfunction

endpackage

// File: rtl/vote_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module vote_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Storage array write port
  always_ff @(posedge clk_in) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vote_frame_parser.sv
// Parses checksummed 5-byte vote frames from the UART byte stream, buffers
// good votes and releases one per downstream request.
module vote_frame_parser
  import vote_pkg::*;
#(
  parameter int NUM_CANDIDATES  = 2,
  parameter int CANDIDATE_WIDTH = 1,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES  = 2_500_000
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         valid_in,
  input  logic [7:0]                   new_byte_in,
  input  logic                         request_new_vote,
  output logic [CANDIDATE_WIDTH-1:0]   vote_out,
  output logic [15:0]                  voter_id_out,
  output logic                         valid_vote_out,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_out,
  output logic [15:0]                  frame_error_count_out,
  output logic                         overflow_out
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int DATA_W = 16 + CANDIDATE_WIDTH;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  parse_state_t                state_r;
  parse_state_t                state_next_s;
  logic [7:0]                  id_hi_r;
  logic [7:0]                  id_lo_r;
  logic [7:0]                  cand_r;
  logic [TMO_W-1:0]            tmo_cnt_r;
  logic                        pending_r;
  logic [CANDIDATE_WIDTH-1:0]  vote_r;
  logic [15:0]                 voter_id_r;
  logic                        valid_vote_r;
  logic [15:0]                 err_cnt_r;
  logic                        overflow_r;

  vote_entry_t                 frame_entry_s;
  logic                        timeout_s;
  logic                        frame_done_s;
  logic                        chk_ok_s;
  logic                        range_ok_s;
  logic                        frame_good_s;
  logic                        frame_bad_s;
  logic                        pop_s;
  logic                        drop_s;
  logic [DATA_W-1:0]           push_data_s;
  logic [DATA_W-1:0]           head_data_s;
  logic                        fifo_full_s;
  logic                        fifo_empty_s;
  logic [CNT_W-1:0]            fifo_count_s;

  assign frame_entry_s = '{voter_id: {id_hi_r, id_lo_r}, candidate: cand_r};
  assign push_data_s   = {frame_entry_s.voter_id, frame_entry_s.candidate[CANDIDATE_WIDTH-1:0]};

  assign timeout_s    = (state_r != SYNC) && !valid_in && (tmo_cnt_r == TMO_LAST);
  assign frame_done_s = (state_r == CHECK) && valid_in;
  assign chk_ok_s     = (new_byte_in == frame_checksum(id_hi_r, id_lo_r, cand_r));
  assign range_ok_s   = ({24'd0, frame_entry_s.candidate} < 32'(NUM_CANDIDATES));
  assign frame_good_s = frame_done_s && chk_ok_s && range_ok_s;
  assign frame_bad_s  = frame_done_s && !(chk_ok_s && range_ok_s);

  // A request in the current cycle pops immediately if a vote is waiting
  assign pop_s  = (pending_r || request_new_vote) && !fifo_empty_s;
  assign drop_s = frame_good_s && fifo_full_s && !pop_s;

  vote_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (frame_good_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .pop_data  (head_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Parser state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= SYNC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Parser next-state: one step per byte; 0xA5 inside a frame is plain data
  always_comb begin
    state_next_s = state_r;
    if (timeout_s) begin
      state_next_s = SYNC;
    end else if (valid_in) begin
      case (state_r)
        SYNC: begin
          if (new_byte_in == SYNC_BYTE) begin
            state_next_s = ID_HI;
          end else begin
            state_next_s = SYNC;
          end
        end
        ID_HI:   state_next_s = ID_LO;
        ID_LO:   state_next_s = CAND;
        CAND:    state_next_s = CHECK;
        CHECK:   state_next_s = SYNC;
        default: state_next_s = SYNC;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame field capture
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      id_hi_r <= 8'd0;
      id_lo_r <= 8'd0;
      cand_r  <= 8'd0;
    end else if (valid_in) begin
      case (state_r)
        ID_HI:   id_hi_r <= new_byte_in;
        ID_LO:   id_lo_r <= new_byte_in;
        CAND:    cand_r  <= new_byte_in;
        default: cand_r  <= cand_r;
      endcase
    end
  end

  // Inter-byte gap counter, idle in SYNC
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r == SYNC) || valid_in || timeout_s) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  // Request latch; requests seen while one is outstanding merge into it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending_r <= 1'b0;
    end else if (pop_s) begin
      pending_r <= 1'b0;
    end else if (request_new_vote) begin
      pending_r <= 1'b1;
    end
  end

  // Released-vote output registers; data holds between strobes
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_vote_r <= 1'b0;
      vote_r       <= {CANDIDATE_WIDTH{1'b0}};
      voter_id_r   <= 16'd0;
    end else begin
      valid_vote_r <= pop_s;
      if (pop_s) begin
        voter_id_r <= head_data_s[DATA_W-1:CANDIDATE_WIDTH];
        vote_r     <= head_data_s[CANDIDATE_WIDTH-1:0];
      end
    end
  end

  // Saturating error counter and sticky overflow flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      err_cnt_r  <= 16'd0;
      overflow_r <= 1'b0;
    end else begin
      if ((frame_bad_s || timeout_s) && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign vote_out              = vote_r;
  assign voter_id_out          = voter_id_r;
  assign valid_vote_out        = valid_vote_r;
  assign fifo_count_out        = fifo_count_s;
  assign frame_error_count_out = err_cnt_r;
  assign overflow_out          = overflow_r;

endmodule

// File: tb/tb_vote_frame_parser.sv
// Scoreboard bench for vote_frame_parser: expected votes are queued as good
// frames are sent and compared against strobes captured by a monitor.
module tb_vote_frame_parser;

  localparam int FD  = 8;
  localparam int TMO = 100;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  new_byte_in = 8'd0;
  logic        request_new_vote = 1'b0;
  logic [0:0]  vote_out;
  logic [15:0] voter_id_out;
  logic        valid_vote_out;
  logic [3:0]  fifo_count_out;
  logic [15:0] frame_error_count_out;
  logic        overflow_out;

  typedef struct packed {
    logic [15:0] id;
    logic [0:0]  vote;
  } vote_t;

  vote_t exp_q[$];
  vote_t obs_q[$];
  int    obs_cyc_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    model_err = 0;

  vote_frame_parser #(
    .NUM_CANDIDATES (2),
    .CANDIDATE_WIDTH(1),
    .FIFO_DEPTH     (FD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .valid_in             (valid_in),
    .new_byte_in          (new_byte_in),
    .request_new_vote     (request_new_vote),
    .vote_out             (vote_out),
    .voter_id_out         (voter_id_out),
    .valid_vote_out       (valid_vote_out),
    .fifo_count_out       (fifo_count_out),
    .frame_error_count_out(frame_error_count_out),
    .overflow_out         (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (valid_vote_out === 1'b1) begin
      obs_q.push_back(vote_t'{id: voter_id_out, vote: vote_out});
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    valid_in    = 1'b1;
    new_byte_in = b;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] id, input logic [7:0] cand,
                            input logic [7:0] chk, input bit req_on_chk);
    bit good;
    good = (chk == (id[15:8] ^ id[7:0] ^ cand)) && (cand < 8'd2);
    send_byte(8'hA5);
    send_byte(id[15:8]);
    send_byte(id[7:0]);
    send_byte(cand);
    if (req_on_chk) request_new_vote = 1'b1;
    send_byte(chk);
    request_new_vote = 1'b0;
    if (!good) model_err++;
    else if (exp_q.size() < FD || req_on_chk) exp_q.push_back(vote_t'{id: id, vote: cand[0]});
  endtask

  task automatic pulse_request(output int req_cyc);
    request_new_vote = 1'b1;
    @(posedge clk_in);
    #1;
    request_new_vote = 1'b0;
    req_cyc = cyc;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic align();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    n_checks++; if (vote_out !== 1'b0) $display("FAIL reset_vote got %h want 0", vote_out); else n_pass++;
    n_checks++; if (voter_id_out !== 16'd0) $display("FAIL reset_id got %h want 0", voter_id_out); else n_pass++;
    n_checks++; if (valid_vote_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_vote_out); else n_pass++;
    n_checks++; if (fifo_count_out !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count_out); else n_pass++;
    n_checks++; if (frame_error_count_out !== 16'd0) $display("FAIL reset_err got %0d want 0", frame_error_count_out); else n_pass++;
    n_checks++; if (overflow_out !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow_out); else n_pass++;
    align();
  endtask

  task automatic test_good_frame();
    int rc, oc; bit ok; vote_t e, o;
    send_frame(16'h1234, 8'h01, 8'h27, 1'b0);
    @(negedge clk_in);
    n_checks++; if (fifo_count_out !== 4'd1) $display("FAIL good_push_count got %0d want 1", fifo_count_out); else n_pass++;
    align();
    pulse_request(rc);
    wait_obs(1, ok);
    n_checks++;
    if (!ok) $display("FAIL good_strobe got none want 1 within bound");
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      if (o !== e || oc !== rc) $display("FAIL good_vote got %h@%0d want %h@%0d", o, oc, e, rc); else n_pass++;
    end
    repeat (4) @(negedge clk_in);
    n_checks++; if (obs_q.size() !== 0) $display("FAIL good_single_strobe got %0d extra want 0", obs_q.size()); else n_pass++;
    n_checks++; if (fifo_count_out !== 4'd0) $display("FAIL good_drain_count got %0d want 0", fifo_count_out); else n_pass++;
    align();
  endtask

  task automatic test_empty_request();
    int rc, chk_cyc, oc; bit ok; vote_t e, o;
    pulse_request(rc);
    repeat (5) @(negedge clk_in);
    n_checks++; if (obs_q.size() !== 0) $display("FAIL empty_no_strobe got %0d want 0", obs_q.size()); else n_pass++;
    align();
    send_frame(16'h0007, 8'h00, 8'h07, 1'b0);
    chk_cyc = cyc;
    wait_obs(1, ok);
    n_checks++;
    if (!ok) $display("FAIL empty_strobe got none want 1 within bound");
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      if (o !== e || oc !== chk_cyc + 1) $display("FAIL empty_vote got %h@%0d want %h@%0d", o, oc, e, chk_cyc + 1); else n_pass++;
    end
    @(negedge clk_in);
    n_checks++; if (fifo_count_out !== 4'd0) $display("FAIL empty_count got %0d want 0", fifo_count_out); else n_pass++;
    align();
  endtask

  task automatic test_bad_frames();
    send_frame(16'h1234, 8'h01, 8'h00, 1'b0);
    send_frame(16'h0000, 8'h05, 8'h05, 1'b0);
    repeat (4) @(negedge clk_in);
    n_checks++; if (frame_error_count_out !== 16'(model_err)) $display("FAIL bad_err got %0d want %0d", frame_error_count_out, model_err); else n_pass++;
    n_checks++; if (fifo_count_out !== 4'd0) $display("FAIL bad_count got %0d want 0", fifo_count_out); else n_pass++;
    n_checks++; if (obs_q.size() !== 0) $display("FAIL bad_no_strobe got %0d want 0", obs_q.size()); else n_pass++;
    align();
  endtask

  task automatic test_timeout();
    int rc, oc; bit ok; vote_t e, o;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h12);
    repeat (TMO + 20) @(posedge clk_in);
    #1;
    model_err++;
    n_checks++; if (frame_error_count_out !== 16'(model_err)) $display("FAIL tmo_err got %0d want %0d", frame_error_count_out, model_err); else n_pass++;
    send_frame(16'h00AB, 8'h01, 8'hAA, 1'b0);
    // byte arriving in the very cycle the timeout would fire keeps the frame
    send_byte(8'hA5);
    repeat (TMO - 1) @(posedge clk_in);
    #1;
    send_byte(8'h0C); send_byte(8'h0D); send_byte(8'h00); send_byte(8'h01);
    exp_q.push_back(vote_t'{id: 16'h0C0D, vote: 1'b0});
    @(negedge clk_in);
    n_checks++; if (frame_error_count_out !== 16'(model_err)) $display("FAIL tmo_edge_err got %0d want %0d", frame_error_count_out, model_err); else n_pass++;
    n_checks++; if (fifo_count_out !== 4'd2) $display("FAIL tmo_count got %0d want 2", fifo_count_out); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      align();
      pulse_request(rc);
      wait_obs(1, ok);
      n_checks++;
      if (!ok) $display("FAIL tmo_strobe got none want 1 within bound");
      else begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e) $display("FAIL tmo_vote got %h want %h", o, e); else n_pass++;
      end
    end
    align();
  endtask

  task automatic test_overflow();
    int rc, oc; bit ok; vote_t e, o;
    for (int i = 1; i <= 9; i++)
      send_frame(16'(i), 8'(i % 2), 8'(i % 256) ^ 8'(i % 2), 1'b0);
    @(negedge clk_in);
    n_checks++; if (fifo_count_out !== 4'd8) $display("FAIL ovf_count got %0d want 8", fifo_count_out); else n_pass++;
    n_checks++; if (overflow_out !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow_out); else n_pass++;
    n_checks++; if (frame_error_count_out !== 16'(model_err)) $display("FAIL ovf_err got %0d want %0d", frame_error_count_out, model_err); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      align();
      pulse_request(rc);
      wait_obs(1, ok);
      n_checks++;
      if (!ok) $display("FAIL ovf_strobe got none want 1 within bound");
      else begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
        if (o !== e || o.id !== 16'(k + 1)) $display("FAIL ovf_order got %h want %h", o, e); else n_pass++;
      end
    end
    repeat (4) @(negedge clk_in);
    n_checks++; if (fifo_count_out !== 4'd0 || obs_q.size() !== 0) $display("FAIL ovf_drain got count %0d strobes %0d want 0 0", fifo_count_out, obs_q.size()); else n_pass++;
    align();
  endtask

  task automatic test_back_to_back();
    bit ok; vote_t e, o; int oc;
    for (int i = 0; i < FD; i++)
      send_frame(16'h0100 + 16'(i), 8'(i % 2), 8'h01 ^ 8'(i) ^ 8'(i % 2), 1'b0);
    send_frame(16'h0200, 8'h00, 8'h02, 1'b1);
    @(negedge clk_in);
    n_checks++; if (fifo_count_out !== 4'd8) $display("FAIL b2b_full_pushpop got %0d want 8", fifo_count_out); else n_pass++;
    align();
    request_new_vote = 1'b1;
    repeat (FD) @(posedge clk_in);
    #1 request_new_vote = 1'b0;
    wait_obs(FD + 1, ok);
    n_checks++; if (!ok) $display("FAIL b2b_strobes got %0d want %0d", obs_q.size(), FD + 1); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL b2b_order got %h want %h", o, e); else n_pass++;
    end
    repeat (3) @(negedge clk_in);
    n_checks++; if (fifo_count_out !== 4'd0 || obs_q.size() !== 0) $display("FAIL b2b_drain got count %0d strobes %0d want 0 0", fifo_count_out, obs_q.size()); else n_pass++;
    align();
  endtask

  task automatic test_reset_mid();
    int rc, oc; bit ok; vote_t e, o;
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    #2 rst_in = 1'b1;
    #1;
    n_checks++; if (frame_error_count_out !== 16'd0 || overflow_out !== 1'b0 || fifo_count_out !== 4'd0)
      $display("FAIL rst_mid_frame got err %0d ovf %b cnt %0d want 0 0 0", frame_error_count_out, overflow_out, fifo_count_out); else n_pass++;
    align();
    rst_in = 1'b0;
    model_err = 0;
    exp_q.delete();
    send_frame(16'h0042, 8'h01, 8'h43, 1'b0);
    pulse_request(rc);
    wait_obs(1, ok);
    n_checks++;
    if (!ok) $display("FAIL rst_resume_strobe got none want 1 within bound");
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      if (o !== e) $display("FAIL rst_resume_vote got %h want %h", o, e); else n_pass++;
    end
    align();
    pulse_request(rc);
    repeat (2) @(negedge clk_in);
    #1 rst_in = 1'b1;
    #1;
    n_checks++; if (voter_id_out !== 16'd0 || vote_out !== 1'b0 || valid_vote_out !== 1'b0)
      $display("FAIL rst_pending got id %h vote %b valid %b want 0 0 0", voter_id_out, vote_out, valid_vote_out); else n_pass++;
    align();
    rst_in = 1'b0;
    send_frame(16'h0055, 8'h00, 8'h55, 1'b0);
    repeat (4) @(negedge clk_in);
    n_checks++; if (obs_q.size() !== 0 || fifo_count_out !== 4'd1)
      $display("FAIL rst_pending_cleared got strobes %0d cnt %0d want 0 1", obs_q.size(), fifo_count_out); else n_pass++;
    align();
    pulse_request(rc);
    wait_obs(1, ok);
    n_checks++;
    if (!ok) $display("FAIL rst_final_strobe got none want 1 within bound");
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
      if (o !== e) $display("FAIL rst_final_vote got %h want %h", o, e); else n_pass++;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_empty_request();
    test_bad_frames();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
